// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC3 memory arbiter, its three requesters and Memory.
//
// Handshake: a requester raises *_req with its address/data stable and holds
// it until the matching one-cycle *_ack pulse. It drops req in the cycle after
// the ack. Read data (*_dout) is valid with the ack and holds until that
// requester's next ack. Toward Memory, mem_en is a one-cycle strobe. mem_addr,
// mem_din and mem_rd stay stable until mem_complete, which may already be high
// in the strobe cycle.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_din;
    logic          ld_ack;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_dout;
    logic          f_ack;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;
    logic          m_ack;

    logic          mem_en;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_complete;

    logic          busy;
    logic [1:0]    grant_id;
    logic          err;
    logic [1:0]    state_dbg;

    // Arbiter side
    modport slave (
        input  ld_req, ld_addr, ld_din, f_req, f_addr,
        input  m_req, m_we, m_addr, m_din, mem_dout, mem_complete,
        output ld_ack, f_dout, f_ack, m_dout, m_ack,
        output mem_en, mem_rd, mem_addr, mem_din,
        output busy, grant_id, err, state_dbg
    );

    // Requester / Memory side
    modport master (
        output ld_req, ld_addr, ld_din, f_req, f_addr,
        output m_req, m_we, m_addr, m_din, mem_dout, mem_complete,
        input  ld_ack, f_dout, f_ack, m_dout, m_ack,
        input  mem_en, mem_rd, mem_addr, mem_din,
        input  busy, grant_id, err, state_dbg
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// LC3 shared memory-port arbiter: loader > MemAccess > Fetch, with Fetch
// promoted over MemAccess after STARVE_LIMIT back-to-back MemAccess grants.
// One access at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// The first IDLE cycle after RESP grants nobody. This gives the just-acked
// requester its cycle to drop req. It also means a requester that keeps req
// high competes again one cycle later.
// Optional build macro MEM_ARB_TIMEOUT_EN: abort an access after TIMEOUT
// cycles without mem_complete, acking with err = 1 and zero read data.
module lc3_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input logic              clk,
    input logic              reset,
    lc3_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_LD   = 2'd1;
    localparam logic [1:0] G_M    = 2'd2;
    localparam logic [1:0] G_F    = 2'd3;

    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    state_t         state;
    logic [SCW-1:0] starve_cnt;
    logic [1:0]     mask;        // owner just acked; nonzero only in the turnaround cycle

    logic [1:0]     win;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_din;
    logic           win_rd;
    logic           promote;
    logic           timed_out;
    logic [DW-1:0]  rdata;

    assign bus.state_dbg = state;
    assign promote       = (starve_cnt == STARVE_MAX);
    // A timed-out read returns zero; a real completion always wins the tie.
    assign rdata         = bus.mem_complete ? bus.mem_dout : {DW{1'b0}};

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
    assign timed_out = !bus.mem_complete && (wait_cnt == TO_CNT);
`else
    assign timed_out = 1'b0;
`endif

    // Pick the winner among current requests and mux its address/data/type.
    always_comb begin
        win      = G_NONE;
        win_addr = '0;
        win_din  = '0;
        win_rd   = 1'b0;
        if (bus.ld_req) begin
            win      = G_LD;
            win_addr = bus.ld_addr;
            win_din  = bus.ld_din;
            win_rd   = 1'b0;
        end else if (bus.f_req && promote) begin
            win      = G_F;
            win_addr = bus.f_addr;
            win_rd   = 1'b1;
        end else if (bus.m_req) begin
            win      = G_M;
            win_addr = bus.m_addr;
            win_din  = bus.m_din;
            win_rd   = !bus.m_we;
        end else if (bus.f_req) begin
            win      = G_F;
            win_addr = bus.f_addr;
            win_rd   = 1'b1;
        end
    end

    // Access sequencer with registered outputs and starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            mask         <= G_NONE;
            bus.ld_ack   <= 1'b0;
            bus.f_ack    <= 1'b0;
            bus.m_ack    <= 1'b0;
            bus.f_dout   <= '0;
            bus.m_dout   <= '0;
            bus.mem_en   <= 1'b0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.busy     <= 1'b0;
            bus.grant_id <= G_NONE;
            bus.err      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            bus.ld_ack <= 1'b0;
            bus.f_ack  <= 1'b0;
            bus.m_ack  <= 1'b0;
            bus.err    <= 1'b0;
            bus.mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (mask != G_NONE) begin
                        mask <= G_NONE;
                    end else if (win != G_NONE) begin
                        state        <= ISSUE;
                        bus.busy     <= 1'b1;
                        bus.mem_en   <= 1'b1;
                        bus.grant_id <= win;
                        bus.mem_addr <= win_addr;
                        bus.mem_din  <= win_din;
                        bus.mem_rd   <= win_rd;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                        if (win == G_F) begin
                            starve_cnt <= '0;
                        end else if (win == G_M) begin
                            if (!bus.f_req) starve_cnt <= '0;
                            else if (!promote) starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (bus.mem_complete || timed_out) begin
                        state   <= RESP;
                        bus.err <= timed_out;
                        case (bus.grant_id)
                            G_LD: bus.ld_ack <= 1'b1;
                            G_M: begin
                                bus.m_ack <= 1'b1;
                                if (bus.mem_rd) bus.m_dout <= rdata;
                            end
                            G_F: begin
                                bus.f_ack  <= 1'b1;
                                bus.f_dout <= rdata;
                            end
                            default: ;
                        endcase
                    end else begin
                        state <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.mem_rd   <= 1'b0;
                    mask         <= bus.grant_id;
                    bus.grant_id <= G_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: reset, a table of single accesses
// with latency checks, a three-way collision, Fetch promotion, reset during an
// access and, when MEM_ARB_TIMEOUT_EN is defined, the timeout path.
module tb_lc3_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    lc3_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int m_ack_cnt = 0;
    // {owner[1:0], err, dout[15:0]}
    logic [18:0] exp_q[$];
    // {owner[1:0], rd, addr[15:0], din[15:0]}
    logic [34:0] mem_q[$];

    // memory responder controls
    int          cur_lat = 0;
    bit          use_fixed = 1'b1;
    bit          resp_enable = 1'b1;
    logic [15:0] fixed_rdata = 16'h0000;

    function automatic logic [15:0] rd_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [1:0] own, input logic rd, input logic [15:0] addr,
                                     input logic [15:0] din, input logic [15:0] dout, input logic e);
        exp_q.push_back({own, e, dout});
        mem_q.push_back({own, rd, addr, din});
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bus.mem_complete = 1'b0;
        bus.mem_dout     = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1 && resp_enable) begin
                for (int k = 0; k < cur_lat; k++) @(negedge clk);
                bus.mem_complete = 1'b1;
                bus.mem_dout     = use_fixed ? fixed_rdata : rd_fn(bus.mem_addr);
                @(negedge clk);
                bus.mem_complete = 1'b0;
                bus.mem_dout     = 16'h0BAD;
            end
        end
    end

    // ---------------- memory-side monitor ----------------
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_en: got addr 0x%0h expected no access", bus.mem_addr);
                end else begin
                    e = mem_q.pop_front();
                    chk("issue_grant_id", bus.grant_id, e[34:33]);
                    chk("issue_mem_rd", bus.mem_rd, e[32]);
                    chk("issue_mem_addr", bus.mem_addr, e[31:16]);
                    if (!e[32]) chk("issue_mem_din", bus.mem_din, e[15:0]);
                    chk("issue_busy", bus.busy, 1);
                end
            end
        end
    end

    // ---------------- ack scoreboard ----------------
    initial begin
        logic [18:0] e;
        int          n;
        logic [1:0]  own;
        forever begin
            @(negedge clk);
            n = int'(bus.ld_ack === 1'b1) + int'(bus.m_ack === 1'b1) + int'(bus.f_ack === 1'b1);
            if (n != 0) begin
                chk("ack_onehot", n, 1);
                own = (bus.ld_ack === 1'b1) ? 2'd1 : (bus.m_ack === 1'b1) ? 2'd2 : 2'd3;
                if (own == 2'd2) m_ack_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got owner %0d expected none", own);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", own, e[18:17]);
                    chk("ack_err", bus.err, e[16]);
                    if (own == 2'd2) chk("m_dout", bus.m_dout, e[15:0]);
                    if (own == 2'd3) chk("f_dout", bus.f_dout, e[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input int who, input int budget, output int at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((who == 1 && bus.ld_ack === 1'b1) || (who == 2 && bus.m_ack === 1'b1) ||
                (who == 3 && bus.f_ack === 1'b1)) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ack_wait: got no ack from owner %0d expected ack within %0d cycles", who, budget);
        end
    endtask

    // Raise a request, wait for its ack, drop it; optionally check req->ack latency.
    task automatic do_req(input int who, input logic we, input logic [15:0] a, input logic [15:0] d,
                          input int lat, input bit check_lat);
        int t0, tack;
        bit ok;
        case (who)
            1: begin bus.ld_addr = a; bus.ld_din = d; bus.ld_req = 1'b1; end
            2: begin bus.m_we = we; bus.m_addr = a; bus.m_din = d; bus.m_req = 1'b1; end
            default: begin bus.f_addr = a; bus.f_req = 1'b1; end
        endcase
        t0 = cyc;
        wait_ack(who, 300, tack, ok);
        case (who)
            1: bus.ld_req = 1'b0;
            2: bus.m_req  = 1'b0;
            default: bus.f_req = 1'b0;
        endcase
        if (check_lat && ok) chk("latency", tack - t0, 2 + lat);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]  who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
        int          lat;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[7];

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  tack, t0;
        bit  ok;
        int  m_before;
        logic rd;

        vecs[0] = '{2'd3, 1'b0, 16'h3000, 16'h0000, 16'h1234, 0, 16'h1234};
        vecs[1] = '{2'd2, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 3, 16'hBEEF};
        vecs[2] = '{2'd2, 1'b1, 16'h4002, 16'hCAFE, 16'h0000, 1, 16'hBEEF};
        vecs[3] = '{2'd1, 1'b1, 16'h0200, 16'h1111, 16'h0000, 0, 16'h0000};
        vecs[4] = '{2'd3, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 7, 16'h0001};
        vecs[5] = '{2'd2, 1'b0, 16'h0000, 16'h0000, 16'h8000, 0, 16'h8000};
        vecs[6] = '{2'd1, 1'b1, 16'hFFFE, 16'hFFFF, 16'h0000, 2, 16'h0000};

        // ---- reset with every request high ----
        reset = 1'b0;
        bus.ld_req = 1'b1; bus.ld_addr = 16'h1111; bus.ld_din = 16'h2222;
        bus.m_req  = 1'b1; bus.m_we = 1'b1; bus.m_addr = 16'h3333; bus.m_din = 16'h4444;
        bus.f_req  = 1'b1; bus.f_addr = 16'h5555;
        repeat (3) @(negedge clk);
        chk("rst_acks", {bus.ld_ack, bus.m_ack, bus.f_ack}, 0);
        chk("rst_douts", {bus.f_dout, bus.m_dout}, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_bus", {bus.mem_rd, bus.mem_addr, bus.mem_din}, 0);
        chk("rst_busy_grant", {bus.busy, bus.grant_id}, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_state", bus.state_dbg, 0);
        bus.ld_req = 1'b0; bus.m_req = 1'b0; bus.f_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // ---- table of single accesses ----
        for (int i = 0; i < 7; i++) begin
            cur_lat     = vecs[i].lat;
            use_fixed   = 1'b1;
            fixed_rdata = vecs[i].rdata;
            rd = (vecs[i].who == 2'd3) || (vecs[i].who == 2'd2 && !vecs[i].we);
            push_exp(vecs[i].who, rd, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, 1'b0);
            do_req(int'(vecs[i].who), vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].lat, 1'b1);
            repeat (3) @(negedge clk);
        end

        // ---- collision: loader, MemAccess, Fetch all at once ----
        cur_lat   = 1;
        use_fixed = 1'b0;
        push_exp(2'd1, 1'b0, 16'h0A00, 16'h5151, 16'h0000, 1'b0);
        push_exp(2'd2, 1'b1, 16'h0B00, 16'h0000, rd_fn(16'h0B00), 1'b0);
        push_exp(2'd3, 1'b1, 16'h0C00, 16'h0000, rd_fn(16'h0C00), 1'b0);
        fork
            do_req(1, 1'b1, 16'h0A00, 16'h5151, 0, 1'b0);
            do_req(2, 1'b0, 16'h0B00, 16'h0000, 0, 1'b0);
            do_req(3, 1'b0, 16'h0C00, 16'h0000, 0, 1'b0);
        join
        repeat (3) @(negedge clk);

        // ---- starvation: MemAccess held, Fetch pending ----
        cur_lat = 0;
        for (int i = 0; i < 4; i++) push_exp(2'd2, 1'b1, 16'h5000, 16'h0000, rd_fn(16'h5000), 1'b0);
        push_exp(2'd3, 1'b1, 16'h6000, 16'h0000, rd_fn(16'h6000), 1'b0);
        m_before = m_ack_cnt;
        bus.m_we = 1'b0; bus.m_addr = 16'h5000; bus.m_din = 16'h0000; bus.f_addr = 16'h6000;
        bus.m_req = 1'b1; bus.f_req = 1'b1;
        wait_ack(3, 200, tack, ok);
        bus.m_req = 1'b0; bus.f_req = 1'b0;
        chk("starve_m_grants", m_ack_cnt - m_before, 4);
        repeat (3) @(negedge clk);

        // ---- reset in WAIT: access abandoned, no ack ----
        cur_lat = 5; use_fixed = 1'b1; fixed_rdata = 16'hDEAD;
        mem_q.push_back({2'd2, 1'b1, 16'h7000, 16'h0000});
        bus.m_we = 1'b0; bus.m_addr = 16'h7000; bus.m_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) begin ok = 1'b1; break; end
        end
        chk("midrst_issue_seen", ok, 1);
        repeat (2) @(negedge clk);
        chk("midrst_in_wait", bus.state_dbg, 2);
        reset = 1'b0;
        bus.m_req = 1'b0;
        @(negedge clk);
        chk("midrst_state", bus.state_dbg, 0);
        chk("midrst_busy_grant", {bus.busy, bus.grant_id}, 0);
        chk("midrst_no_ack", bus.m_ack, 0);
        reset = 1'b1;
        m_before = m_ack_cnt;
        repeat (8) @(negedge clk);
        chk("midrst_late_no_ack", m_ack_cnt - m_before, 0);
        chk("midrst_m_dout", bus.m_dout, 0);
        chk("midrst_idle", bus.state_dbg, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- timeout: complete never arrives ----
        cur_lat = 0; use_fixed = 1'b0;
        push_exp(2'd2, 1'b1, 16'h5000, 16'h0000, rd_fn(16'h5000), 1'b0);
        do_req(2, 1'b0, 16'h5000, 16'h0000, 0, 1'b1);
        repeat (3) @(negedge clk);
        resp_enable = 1'b0;
        push_exp(2'd2, 1'b1, 16'h8000, 16'h0000, 16'h0000, 1'b1);
        bus.m_we = 1'b0; bus.m_addr = 16'h8000; bus.m_req = 1'b1;
        t0 = cyc;
        wait_ack(2, 100, tack, ok);
        bus.m_req = 1'b0;
        if (ok) chk("timeout_cycle", tack - t0, 66);
        resp_enable = 1'b1;
        repeat (3) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
